// File: rtl/message_reader.sv
// message_reader: streams a little-endian word buffer from data memory
// out as bytes over a valid/ready handshake, kicked by a start strobe.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, msg_len       begin read-out of msg_len bytes (sampled in IDLE)
//   mem_rd_en, mem_addr  synchronous-read memory request (word address)
//   mem_rdata            read data, valid the cycle after mem_rd_en
//   out_byte, out_valid  byte stream towards the consumer
//   out_ready            consumer accepts out_byte this cycle
//   busy, done           activity flag and end-of-message pulse
module message_reader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_LEN   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        msg_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0]        MAX_B = 8'(MAX_LEN);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    logic [2:0]        state;
    logic [7:0]        len;
    logic [7:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       buffer;
    logic [1:0]        lane;

    logic [7:0]        cnt_next;
    logic [1:0]        lane_next;
    logic [7:0]        next_byte;
    logic [ADDR_W-1:0] idx_next;

    assign cnt_next  = byte_cnt + 8'd1;
    assign lane_next = lane + 2'd1;
    assign idx_next  = word_idx + ADDR_W'(1);
    // Byte shown after an acceptance; wraps to lane 0 harmlessly
    // when a refill follows, since WAIT reloads out_byte anyway.
    assign next_byte = buffer[{lane_next, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= 8'd0;
            byte_cnt <= 8'd0;
            word_idx <= '0;
            buffer   <= 32'd0;
            lane     <= 2'd0;
            mem_addr <= '0;
            out_byte <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len      <= (msg_len > MAX_B) ? MAX_B : msg_len;
                        byte_cnt <= 8'd0;
                        word_idx <= '0;
                        mem_addr <= BASE;
                        state    <= (msg_len == 8'd0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    buffer   <= mem_rdata;
                    lane     <= 2'd0;
                    out_byte <= mem_rdata[7:0];
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        byte_cnt <= cnt_next;
                        lane     <= lane_next;
                        out_byte <= next_byte;
                        if (cnt_next == len) begin
                            state <= S_DONE;
                        end else if (lane == 2'd3) begin
                            word_idx <= idx_next;
                            mem_addr <= BASE + idx_next;
                            state    <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en = (state == S_REQ);
    assign out_valid = (state == S_SEND);
    assign busy      = (state == S_REQ) || (state == S_WAIT)
                    || (state == S_SEND);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_message_reader.sv
// tb_message_reader: randomized self-checking bench for message_reader,
// two instances (base 0 and base 254) sharing one memory image.
module tb_message_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  msg_len;
    logic        out_ready;

    logic        rd_a, valid_a, busy_a, done_a;
    logic [7:0]  addr_a, byte_a;
    logic [31:0] rdata_a;
    logic        rd_b, valid_b, busy_b, done_b;
    logic [7:0]  addr_b, byte_b;
    logic [31:0] rdata_b;

    logic [31:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    message_reader #(.ADDR_W(8), .BASE_ADDR(0), .MAX_LEN(64)) u_a (
        .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .out_byte(byte_a), .out_valid(valid_a), .out_ready(out_ready),
        .busy(busy_a), .done(done_a)
    );

    message_reader #(.ADDR_W(8), .BASE_ADDR(254), .MAX_LEN(64)) u_b (
        .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .out_byte(byte_b), .out_valid(valid_b), .out_ready(out_ready),
        .busy(busy_b), .done(done_b)
    );

    always_ff @(posedge clk) begin
        if (rd_a) rdata_a <= mem[addr_a];
        if (rd_b) rdata_b <= mem[addr_b];
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] exp_byte(int base, int i);
        logic [31:0] w;
        w = mem[(base + i / 4) % 256];
        return w[(8 * (i % 4)) +: 8];
    endfunction

    function automatic int clamp(int len);
        return (len > 64) ? 64 : len;
    endfunction

    function automatic int exp_done(int n, int st);
        return (n == 0) ? 1 : 2 * ((n + 3) / 4) + n + st + 1;
    endfunction

    // ---------------- observations of one run ----------------
    logic [7:0] bytes_a[$], bytes_b[$], reads_a[$], reads_b[$];
    int first_valid, done_cyc, stalls, valid_cnt;
    int stall_bad, busy_bad, ab_bad, timeout;
    logic post_done, post_busy;

    task automatic run_msg(input int len, input int mode);
        int cyc, pidx, n;
        logic r, prev_stall;
        logic [7:0] prev_byte;
        bytes_a.delete(); bytes_b.delete();
        reads_a.delete(); reads_b.delete();
        first_valid = -1; done_cyc = -1; stalls = 0; valid_cnt = 0;
        stall_bad = 0; busy_bad = 0; ab_bad = 0; timeout = 0;
        n = clamp(len);
        cyc = 0; pidx = 0; prev_stall = 1'b0; prev_byte = 8'd0;
        @(negedge clk);
        start = 1'b1; msg_len = 8'(len); out_ready = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            msg_len = 8'($urandom);
            if (rd_a) reads_a.push_back(addr_a);
            if (rd_b) reads_b.push_back(addr_b);
            if (valid_a !== valid_b || done_a !== done_b) ab_bad++;
            if (prev_stall && (byte_a !== prev_byte || !valid_a))
                stall_bad++;
            if (busy_a !== ((n > 0) && !done_a)) busy_bad++;
            if (done_a) begin
                done_cyc = cyc;
                break;
            end
            if (cyc > 1000) begin
                timeout = 1;
                break;
            end
            case (mode)
                0: r = 1'b1;
                1: r = (pidx % 4 == 0) || (pidx % 4 == 3);
                default: r = 1'($urandom);
            endcase
            out_ready = r;
            if (valid_a) begin
                pidx++;
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                if (r) begin
                    bytes_a.push_back(byte_a);
                    bytes_b.push_back(byte_b);
                end else begin
                    stalls++;
                end
            end
            prev_stall = valid_a && !r;
            prev_byte  = byte_a;
        end
        @(negedge clk);
        post_done = done_a;
        post_busy = busy_a;
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({rd_a, addr_a, byte_a, valid_a, busy_a, done_a} !== 20'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %0h expected 0",
                         {rd_a, addr_a, byte_a, valid_a, busy_a, done_a});
            end
            start = 1'($urandom);
            msg_len = 8'($urandom);
            out_ready = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({rd_a, valid_a, busy_a, done_a, busy_b} !== 5'd0) begin
                n_bad++;
                $display("FAIL reset_start_ignored: got %0h expected 0",
                         {rd_a, valid_a, busy_a, done_a, busy_b});
            end
        end
    endtask

    task automatic test_basic();
        mem[0] = 32'h44434241;
        mem[1] = 32'h00004645;
        run_msg(6, 0);
        n_cmp++;
        if (bytes_a.size() !== 6) begin
            n_bad++;
            $display("FAIL basic_count: got %0d expected 6", bytes_a.size());
        end
        for (int i = 0; i < bytes_a.size() && i < 6; i++) begin
            n_cmp++;
            if (bytes_a[i] !== 8'h41 + 8'(i)) begin
                n_bad++;
                $display("FAIL basic_byte%0d: got %0h expected %0h",
                         i, bytes_a[i], 8'h41 + 8'(i));
            end
        end
        n_cmp++;
        if (reads_a.size() !== 2 || reads_a[0] !== 8'd0 || reads_a[1] !== 8'd1) begin
            n_bad++;
            $display("FAIL basic_reads: got %0d reads expected 2 at 0,1",
                     reads_a.size());
        end
        n_cmp++;
        if (first_valid !== 3) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d expected 3", first_valid);
        end
        n_cmp++;
        if (done_cyc !== 11) begin
            n_bad++;
            $display("FAIL basic_done_cycle: got %0d expected 11", done_cyc);
        end
        n_cmp++;
        if ({post_done, post_busy, busy_bad, ab_bad, timeout} !== '0) begin
            n_bad++;
            $display("FAIL basic_flags: got pd=%0b pb=%0b bb=%0d ab=%0d to=%0d expected 0",
                     post_done, post_busy, busy_bad, ab_bad, timeout);
        end
    endtask

    task automatic test_backpressure();
        run_msg(6, 1);
        n_cmp++;
        if (bytes_a.size() !== 6) begin
            n_bad++;
            $display("FAIL bp_count: got %0d expected 6", bytes_a.size());
        end
        for (int i = 0; i < bytes_a.size() && i < 6; i++) begin
            n_cmp++;
            if (bytes_a[i] !== exp_byte(0, i)) begin
                n_bad++;
                $display("FAIL bp_byte%0d: got %0h expected %0h",
                         i, bytes_a[i], exp_byte(0, i));
            end
        end
        n_cmp++;
        if (stall_bad !== 0 || stalls == 0) begin
            n_bad++;
            $display("FAIL bp_stall: got bad=%0d stalls=%0d expected 0 bad",
                     stall_bad, stalls);
        end
        n_cmp++;
        if (reads_a.size() !== 2) begin
            n_bad++;
            $display("FAIL bp_reads: got %0d expected 2", reads_a.size());
        end
        n_cmp++;
        if (done_cyc !== exp_done(6, stalls)) begin
            n_bad++;
            $display("FAIL bp_done_cycle: got %0d expected %0d",
                     done_cyc, exp_done(6, stalls));
        end
    endtask

    task automatic test_zero_len();
        run_msg(0, 0);
        n_cmp++;
        if (done_cyc !== 1) begin
            n_bad++;
            $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc);
        end
        n_cmp++;
        if (reads_a.size() + reads_b.size() + valid_cnt !== 0) begin
            n_bad++;
            $display("FAIL zero_activity: got reads=%0d valid=%0d expected 0",
                     reads_a.size(), valid_cnt);
        end
        n_cmp++;
        if ({post_done, busy_bad} !== '0) begin
            n_bad++;
            $display("FAIL zero_flags: got pd=%0b bb=%0d expected 0",
                     post_done, busy_bad);
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        run_msg(200, 0);
        n_cmp++;
        if (bytes_a.size() !== 64 || reads_a.size() !== 16) begin
            n_bad++;
            $display("FAIL clamp_sizes: got bytes=%0d reads=%0d expected 64/16",
                     bytes_a.size(), reads_a.size());
        end
        for (int i = 0; i < bytes_a.size() && i < 64; i++) begin
            n_cmp++;
            if (bytes_a[i] !== exp_byte(0, i)) begin
                n_bad++;
                $display("FAIL clamp_byte%0d: got %0h expected %0h",
                         i, bytes_a[i], exp_byte(0, i));
            end
        end
    endtask

    task automatic test_wrap();
        run_msg(12, 0);
        n_cmp++;
        if (reads_b.size() !== 3) begin
            n_bad++;
            $display("FAIL wrap_reads: got %0d expected 3", reads_b.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (int'(reads_b[k]) !== (254 + k) % 256) begin
                    n_bad++;
                    $display("FAIL wrap_addr%0d: got %0d expected %0d",
                             k, reads_b[k], (254 + k) % 256);
                end
            end
        end
        for (int i = 0; i < bytes_b.size() && i < 12; i++) begin
            n_cmp++;
            if (bytes_b[i] !== exp_byte(254, i)) begin
                n_bad++;
                $display("FAIL wrap_byte%0d: got %0h expected %0h",
                         i, bytes_b[i], exp_byte(254, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc, cyc;
        acc = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1; msg_len = 8'd12; out_ready = 1'b1;
        while (acc < 2 && cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (valid_a) acc++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (acc !== 2 || {valid_a, busy_a, done_a, rd_a} !== 4'd0) begin
            n_bad++;
            $display("FAIL midrst_idle: got acc=%0d v=%0b b=%0b d=%0b expected 2/0",
                     acc, valid_a, busy_a, done_a);
        end
        rst = 1'b0; out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_a || valid_a) acc++;
        end
        n_cmp++;
        if (acc !== 0) begin
            n_bad++;
            $display("FAIL midrst_no_done: got %0d active cycles expected 0", acc);
        end
        run_msg(12, 0);
        n_cmp++;
        if (bytes_a.size() !== 12 || done_cyc !== exp_done(12, 0)) begin
            n_bad++;
            $display("FAIL midrst_replay: got n=%0d done=%0d expected 12/%0d",
                     bytes_a.size(), done_cyc, exp_done(12, 0));
        end
        for (int i = 0; i < bytes_a.size() && i < 12; i++) begin
            n_cmp++;
            if (bytes_a[i] !== exp_byte(0, i)) begin
                n_bad++;
                $display("FAIL midrst_byte%0d: got %0h expected %0h",
                         i, bytes_a[i], exp_byte(0, i));
            end
        end
    endtask

    task automatic test_random();
        int len, n, errs;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            len = $urandom_range(1, 90);
            n = clamp(len);
            run_msg(len, 2);
            errs = 0;
            if (bytes_a.size() != n || bytes_b.size() != n) errs++;
            for (int i = 0; i < bytes_a.size() && i < n; i++) begin
                if (bytes_a[i] !== exp_byte(0, i)) errs++;
                if (bytes_b[i] !== exp_byte(254, i)) errs++;
            end
            n_cmp++;
            if (errs !== 0) begin
                n_bad++;
                $display("FAIL rand%0d_bytes: got %0d bad bytes of %0d expected 0",
                         it, errs, n);
            end
            n_cmp++;
            if (reads_a.size() !== (n + 3) / 4
                || done_cyc !== exp_done(n, stalls)) begin
                n_bad++;
                $display("FAIL rand%0d_timing: got reads=%0d done=%0d expected %0d/%0d",
                         it, reads_a.size(), done_cyc, (n + 3) / 4,
                         exp_done(n, stalls));
            end
            n_cmp++;
            if ({stall_bad, busy_bad, ab_bad, timeout} !== '0
                || post_done !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_flags: got sb=%0d bb=%0d ab=%0d to=%0d expected 0",
                         it, stall_bad, busy_bad, ab_bad, timeout);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; msg_len = 8'd0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_clamp();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
